// File: rtl/dac_update_sequencer.sv
// Ready-driven MSB/LSB byte sequencer between the DPLL loop filter and the SPI master.
// Define SLEW_LIMIT_EN to clamp each committed code to within SLEW_MAX of the previous one.
module dac_update_sequencer #(
   parameter logic [15:0] DAC_RESET  = 16'h8CCD,
   parameter logic [15:0] SLEW_MAX   = 16'd4096,
   parameter logic [7:0]  GAP_CYCLES = 8'd50,
   parameter logic [15:0] TIMEOUT    = 16'd1000
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic [15:0] code_in,
   input  logic        code_valid,
   output logic        code_ready,
   output logic [7:0]  spi_tx_byte,
   output logic        spi_tx_dv,
   input  logic        spi_tx_ready,
   output logic [15:0] dac_code_out,
   output logic        busy,
   output logic [15:0] frame_count,
   output logic        err_overrun,
   output logic        err_timeout
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StSendMsb, StWaitMsb, StSendLsb, StWaitLsb, StGap
   } state_e;

   state_e      state_q, state_d;
   logic        hold_full_q, hold_full_d;
   logic [15:0] hold_q, code_q, target_q, target_d, dac_q, frame_q, tmr_q, tmr_d;
   logic [7:0]  byte_q;
   logic        ovr_q, tmo_q;
   logic        in_idle, accept, hold_load, timed, tmo_hit, commit, tmo_event;

   if (GAP_CYCLES == 8'd0 || TIMEOUT < 16'd2 || SLEW_MAX == 16'd0) begin : g_param_check
      $error("dac_update_sequencer: GAP_CYCLES and SLEW_MAX must be nonzero, TIMEOUT >= 2");
   end

   assign in_idle    = (state_q == StIdle);
   // IDLE always drains the holding register, so a code offered then is never lost.
   assign code_ready = !hold_full_q || in_idle;
   assign accept     = code_valid && code_ready;
   // An idle, empty sequencer takes the code straight into LOAD without parking it.
   assign hold_load  = accept && !(in_idle && !hold_full_q);
   assign timed      = state_q inside {StSendMsb, StWaitMsb, StSendLsb, StWaitLsb};
   assign tmo_hit    = timed && (tmr_q >= TIMEOUT - 16'd1);

   always_comb begin
      hold_full_d = hold_full_q;
      if (hold_load) hold_full_d = 1'b1;
      else if (in_idle) hold_full_d = 1'b0;
   end

`ifdef SLEW_LIMIT_EN
   logic signed [16:0] diff;
   logic [16:0]        up_sum;

   always_comb begin
      diff   = $signed({1'b0, code_q}) - $signed({1'b0, dac_q});
      up_sum = {1'b0, dac_q} + {1'b0, SLEW_MAX};
      if (diff > $signed({1'b0, SLEW_MAX})) begin
         target_d = up_sum[16] ? 16'hFFFF : up_sum[15:0];
      end else if (diff < -$signed({1'b0, SLEW_MAX})) begin
         target_d = (dac_q < SLEW_MAX) ? 16'h0000 : dac_q - SLEW_MAX;
      end else begin
         target_d = code_q;
      end
   end
`else
   assign target_d = code_q;
`endif

   always_ff @(posedge clk50) begin
      if (reset) state_q <= StIdle;
      else state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      commit    = 1'b0;
      tmo_event = 1'b0;
      unique case (state_q)
         StIdle:    if (hold_full_q || code_valid) state_d = StLoad;
         StLoad:    state_d = StSendMsb;
         StSendMsb: begin
            if (spi_tx_ready) state_d = StWaitMsb;
            else if (tmo_hit) begin state_d = StGap; tmo_event = 1'b1; end
         end
         // The master's ready lags dv by a cycle, so the first WAIT cycle is not trusted.
         StWaitMsb: begin
            if (tmr_q != 16'd0 && spi_tx_ready) state_d = StSendLsb;
            else if (tmo_hit) begin state_d = StGap; tmo_event = 1'b1; end
         end
         StSendLsb: begin
            if (spi_tx_ready) state_d = StWaitLsb;
            else if (tmo_hit) begin state_d = StGap; tmo_event = 1'b1; end
         end
         StWaitLsb: begin
            if (tmr_q != 16'd0 && spi_tx_ready) begin state_d = StGap; commit = 1'b1; end
            else if (tmo_hit) begin state_d = StGap; tmo_event = 1'b1; end
         end
         StGap:     if (tmr_q == {8'd0, GAP_CYCLES} - 16'd1) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      tmr_d = 16'd0;
      if (state_d == state_q && (timed || state_q == StGap)) tmr_d = tmr_q + 16'd1;
   end

   always_comb begin
      busy        = !in_idle;
      spi_tx_dv   = 1'b0;
      spi_tx_byte = byte_q;
      if (state_q == StSendMsb && spi_tx_ready) begin
         spi_tx_dv   = 1'b1;
         spi_tx_byte = target_q[15:8];
      end else if (state_q == StSendLsb && spi_tx_ready) begin
         spi_tx_dv   = 1'b1;
         spi_tx_byte = target_q[7:0];
      end
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         hold_full_q <= 1'b0;
         hold_q      <= 16'd0;
         code_q      <= 16'd0;
         target_q    <= 16'd0;
         dac_q       <= DAC_RESET;
         frame_q     <= 16'd0;
         tmr_q       <= 16'd0;
         byte_q      <= 8'd0;
         ovr_q       <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         if (hold_load) hold_q <= code_in;
         if (in_idle) code_q <= hold_full_q ? hold_q : code_in;
         if (state_q == StLoad) target_q <= target_d;
         if (commit) begin
            dac_q   <= target_q;
            frame_q <= frame_q + 16'd1;
         end
         tmr_q <= tmr_d;
         if (spi_tx_dv) byte_q <= spi_tx_byte;
         if (code_valid && !code_ready) ovr_q <= 1'b1;
         if (tmo_event) tmo_q <= 1'b1;
      end
   end

   assign dac_code_out = dac_q;
   assign frame_count  = frame_q;
   assign err_overrun  = ovr_q;
   assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Directed bench for dac_update_sequencer with a simple byte-handshake SPI master model.
// Expectations follow the SLEW_LIMIT_EN setting of the build.
module tb_dac_update_sequencer;
   localparam int SpiBusy = 20;

   logic        clk50 = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] code_in = 16'd0;
   logic        code_valid = 1'b0;
   logic        code_ready;
   logic [7:0]  spi_tx_byte;
   logic        spi_tx_dv;
   logic        spi_ready = 1'b1;
   logic [15:0] dac_code_out;
   logic        busy;
   logic [15:0] frame_count;
   logic        err_overrun;
   logic        err_timeout;

   int          total = 0;
   int          bad = 0;
   logic        stall = 1'b0;
   int          spi_cnt = 0;
   int          dv_total = 0;
   logic [7:0]  tx_log [0:63];

   dac_update_sequencer dut (
      .clk50        (clk50),
      .reset        (reset),
      .code_in      (code_in),
      .code_valid   (code_valid),
      .code_ready   (code_ready),
      .spi_tx_byte  (spi_tx_byte),
      .spi_tx_dv    (spi_tx_dv),
      .spi_tx_ready (spi_ready),
      .dac_code_out (dac_code_out),
      .busy         (busy),
      .frame_count  (frame_count),
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout)
   );

   always #10 clk50 = ~clk50;

   // SPI master model: ready drops after each dv and returns SpiBusy cycles later.
   always @(posedge clk50) begin
      if (reset) begin
         spi_ready <= 1'b1;
         spi_cnt   <= 0;
      end else if (spi_tx_dv) begin
         spi_ready                <= 1'b0;
         spi_cnt                  <= SpiBusy;
         tx_log[dv_total % 64]    <= spi_tx_byte;
         dv_total                 <= dv_total + 1;
      end else if (spi_cnt != 0) begin
         spi_cnt <= spi_cnt - 1;
      end else if (!stall) begin
         spi_ready <= 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk50);
      #1;
   endtask

   task automatic apply_reset();
      reset      = 1'b1;
      code_valid = 1'b0;
      stall      = 1'b0;
      tick(3);
      reset = 1'b0;
   endtask

   task automatic send_code(input logic [15:0] v);
      code_in    = v;
      code_valid = 1'b1;
      tick(1);
      code_valid = 1'b0;
   endtask

   task automatic wait_frame(input logic [15:0] exp, input int budget);
      int c = 0;
      while (frame_count !== exp && c < budget) begin
         tick(1);
         c++;
      end
   endtask

   task automatic wait_idle(input int budget, output int c);
      c = 0;
      while (busy !== 1'b0 && c < budget) begin
         tick(1);
         c++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (dac_code_out !== 16'h8CCD) begin bad++; $display("FAIL reset_dac got %h want 8ccd", dac_code_out); end
      total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", code_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      total++; if (spi_tx_dv !== 1'b0) begin bad++; $display("FAIL reset_dv got %b want 0", spi_tx_dv); end
      total++; if (spi_tx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte got %h want 00", spi_tx_byte); end
      total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frames got %0d want 0", frame_count); end
      total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got %b want 0", err_overrun); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got %b want 0", err_timeout); end
   endtask

   task automatic test_single_frame();
      int n0, c;
      apply_reset();
      n0 = dv_total;
      send_code(16'h9000);
      total++; if (busy !== 1'b1 || spi_tx_dv !== 1'b0) begin bad++; $display("FAIL single_load busy=%b dv=%b want busy=1 dv=0", busy, spi_tx_dv); end
      tick(1);
      total++; if (spi_tx_dv !== 1'b1 || spi_tx_byte !== 8'h90) begin bad++; $display("FAIL single_msb_dv dv=%b byte=%h want dv=1 byte=90", spi_tx_dv, spi_tx_byte); end
      tick(3);
      total++; if (spi_tx_dv !== 1'b0 || spi_tx_byte !== 8'h90) begin bad++; $display("FAIL single_byte_hold dv=%b byte=%h want dv=0 byte=90", spi_tx_dv, spi_tx_byte); end
      wait_frame(16'd1, 200);
      total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL single_frames got %0d want 1", frame_count); end
      total++; if (dac_code_out !== 16'h9000) begin bad++; $display("FAIL single_dac got %h want 9000", dac_code_out); end
      total++; if (dv_total - n0 !== 2 || tx_log[n0 % 64] !== 8'h90 || tx_log[(n0 + 1) % 64] !== 8'h00) begin
         bad++; $display("FAIL single_bytes got n=%0d %h %h want n=2 90 00", dv_total - n0, tx_log[n0 % 64], tx_log[(n0 + 1) % 64]);
      end
      wait_idle(200, c);
      total++; if (c !== 50) begin bad++; $display("FAIL single_gap_len got %0d want 50", c); end
   endtask

   task automatic test_slew();
      logic [15:0] exp, fc;
      int n0, c;
      apply_reset();
      n0 = dv_total;
      send_code(16'hFFFF);
      wait_frame(16'd1, 300);
`ifdef SLEW_LIMIT_EN
      exp = 16'h9CCD;
`else
      exp = 16'hFFFF;
`endif
      total++; if (dac_code_out !== exp) begin bad++; $display("FAIL slew_up_dac got %h want %h", dac_code_out, exp); end
      total++; if (dv_total - n0 !== 2 || tx_log[n0 % 64] !== exp[15:8] || tx_log[(n0 + 1) % 64] !== exp[7:0]) begin
         bad++; $display("FAIL slew_up_bytes got n=%0d %h %h want n=2 %h %h", dv_total - n0, tx_log[n0 % 64], tx_log[(n0 + 1) % 64], exp[15:8], exp[7:0]);
      end
      wait_idle(200, c);
      fc = 16'd1;
      while (exp != 16'h0800) begin
`ifdef SLEW_LIMIT_EN
         exp = (exp > 16'h1800) ? exp - 16'h1000 : 16'h0800;
`else
         exp = 16'h0800;
`endif
         fc = fc + 16'd1;
         send_code(16'h0800);
         wait_frame(fc, 300);
         total++; if (frame_count !== fc || dac_code_out !== exp) begin
            bad++; $display("FAIL slew_down_step got frames=%0d dac=%h want frames=%0d dac=%h", frame_count, dac_code_out, fc, exp);
         end
         wait_idle(200, c);
      end
      fc = fc + 16'd1;
      n0 = dv_total;
      send_code(16'h0000);
      wait_frame(fc, 300);
      total++; if (dac_code_out !== 16'h0000 || frame_count !== fc) begin bad++; $display("FAIL slew_floor got dac=%h frames=%0d want 0000 %0d", dac_code_out, frame_count, fc); end
      total++; if (dv_total - n0 !== 2 || tx_log[n0 % 64] !== 8'h00 || tx_log[(n0 + 1) % 64] !== 8'h00) begin
         bad++; $display("FAIL slew_floor_bytes got n=%0d %h %h want n=2 00 00", dv_total - n0, tx_log[n0 % 64], tx_log[(n0 + 1) % 64]);
      end
      wait_idle(200, c);
   endtask

   task automatic test_overrun();
      int n0, c;
      apply_reset();
      n0 = dv_total;
      send_code(16'h9000);
      tick(5);
      send_code(16'h9800);
      total++; if (code_ready !== 1'b0 || err_overrun !== 1'b0) begin bad++; $display("FAIL ovr_held got ready=%b ovr=%b want 0 0", code_ready, err_overrun); end
      tick(3);
      send_code(16'hA000);
      total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got %b want 1", err_overrun); end
      wait_frame(16'd2, 600);
      total++; if (frame_count !== 16'd2 || dac_code_out !== 16'h9800) begin bad++; $display("FAIL ovr_second got frames=%0d dac=%h want 2 9800", frame_count, dac_code_out); end
      total++; if (dv_total - n0 !== 4 || tx_log[(n0 + 2) % 64] !== 8'h98 || tx_log[(n0 + 3) % 64] !== 8'h00) begin
         bad++; $display("FAIL ovr_bytes got n=%0d %h %h want n=4 98 00", dv_total - n0, tx_log[(n0 + 2) % 64], tx_log[(n0 + 3) % 64]);
      end
      wait_idle(200, c);
      tick(5);
      total++; if (frame_count !== 16'd2 || busy !== 1'b0 || code_ready !== 1'b1 || err_overrun !== 1'b1) begin
         bad++; $display("FAIL ovr_drop got frames=%0d busy=%b ready=%b ovr=%b want 2 0 1 1", frame_count, busy, code_ready, err_overrun);
      end
   endtask

   task automatic test_timeout();
      int n0, c;
      apply_reset();
      stall = 1'b1;
      n0 = dv_total;
      send_code(16'h9000);
      c = 0;
      while (dv_total == n0 && c < 10) begin tick(1); c++; end
      total++; if (dv_total - n0 !== 1) begin bad++; $display("FAIL tmo_msb_dv got n=%0d want 1", dv_total - n0); end
      tick(999);
      total++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early got tmo=%b busy=%b want 0 1", err_timeout, busy); end
      tick(1);
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag got %b want 1", err_timeout); end
      total++; if (dac_code_out !== 16'h8CCD || frame_count !== 16'd0) begin bad++; $display("FAIL tmo_nocommit got dac=%h frames=%0d want 8ccd 0", dac_code_out, frame_count); end
      stall = 1'b0;
      wait_idle(100, c);
      total++; if (busy !== 1'b0 || dv_total - n0 !== 1 || err_timeout !== 1'b1) begin
         bad++; $display("FAIL tmo_idle got busy=%b n=%0d tmo=%b want 0 1 1", busy, dv_total - n0, err_timeout);
      end
   endtask

   task automatic test_reset_mid_frame();
      int n0, n1, c;
      logic [15:0] exp;
      apply_reset();
      n0 = dv_total;
      send_code(16'h9000);
      c = 0;
      while (dv_total - n0 < 2 && c < 200) begin tick(1); c++; end
      total++; if (dv_total - n0 !== 2) begin bad++; $display("FAIL mid_lsb_sent got n=%0d want 2", dv_total - n0); end
      tick(3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      n1 = dv_total;
      tick(40);
      total++; if (dv_total !== n1 || busy !== 1'b0) begin bad++; $display("FAIL mid_abort got dv=%0d busy=%b want 0 0", dv_total - n1, busy); end
      total++; if (dac_code_out !== 16'h8CCD || frame_count !== 16'd0) begin bad++; $display("FAIL mid_nocommit got dac=%h frames=%0d want 8ccd 0", dac_code_out, frame_count); end
      n0 = dv_total;
      send_code(16'h1234);
      wait_frame(16'd1, 300);
`ifdef SLEW_LIMIT_EN
      exp = 16'h7CCD;
`else
      exp = 16'h1234;
`endif
      total++; if (dac_code_out !== exp || frame_count !== 16'd1) begin bad++; $display("FAIL mid_next got dac=%h frames=%0d want %h 1", dac_code_out, frame_count, exp); end
      total++; if (dv_total - n0 !== 2 || tx_log[n0 % 64] !== exp[15:8] || tx_log[(n0 + 1) % 64] !== exp[7:0]) begin
         bad++; $display("FAIL mid_next_bytes got n=%0d %h %h want n=2 %h %h", dv_total - n0, tx_log[n0 % 64], tx_log[(n0 + 1) % 64], exp[15:8], exp[7:0]);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_slew();
      test_overrun();
      test_timeout();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
